// File: rtl/sd_bd_fetch_if.sv
// Handshake bundle between the BD fetch stage, the BD store and the SD data engine.
// The fetch stage is the master; the BD store / data engine side is the slave.
interface sd_bd_fetch_if #(
    parameter int DATA_W = 32,
    parameter int BD_W   = 3
);
    logic [BD_W-1:0]   free_bd;
    logic              bd_re;
    logic              bd_ack;
    logic [DATA_W-1:0] bd_dat;
    logic              bd_cmp;
    logic              xfer_start;
    logic [DATA_W-1:0] xfer_sys_addr;
    logic [DATA_W-1:0] xfer_blk_addr;
    logic              xfer_done;
    logic              xfer_err;

    modport master (
        input  free_bd, bd_ack, bd_dat, xfer_done, xfer_err,
        output bd_re, bd_cmp, xfer_start, xfer_sys_addr, xfer_blk_addr
    );

    modport slave (
        output free_bd, bd_ack, bd_dat, xfer_done, xfer_err,
        input  bd_re, bd_cmp, xfer_start, xfer_sys_addr, xfer_blk_addr
    );
endinterface

// File: rtl/sd_bd_fetch.sv
// SD DMA buffer-descriptor fetch stage: reads queued BDs (system address, then block
// address), launches one block transfer each, and retires the BD on done/error/timeout.
module sd_bd_fetch #(
    parameter int DATA_W = 32,
    parameter int BD_W   = 3,
    parameter int BD_MAX = 4,
    parameter int TMO_W  = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    sd_bd_fetch_if.master     bus,
    output logic              busy,
    output logic              err,
    input  logic              err_clr,
    output logic [DATA_W-1:0] err_blk_addr,
    output logic [15:0]       xfer_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_SYS = 3'd1,
        S_RD_BLK = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_CMP    = 3'd5,
        S_SETTLE = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic               bd_re_q, bd_re_d;
    logic               bd_cmp_q, bd_cmp_d;
    logic               xfer_start_q, xfer_start_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  sys_addr_q, sys_addr_d;
    logic [DATA_W-1:0]  blk_addr_q, blk_addr_d;
    logic [DATA_W-1:0]  err_blk_q, err_blk_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [TMO_W-1:0]   tmo_inc;
    logic               pending;
    logic               retire;
    logic               fail;

    assign pending = (bus.free_bd != BD_W'(BD_MAX));
    assign tmo_inc = tmo_q + TMO_W'(1);

    always_comb begin
        state_d      = state_q;
        bd_re_d      = 1'b0;
        bd_cmp_d     = 1'b0;
        xfer_start_d = 1'b0;
        sys_addr_d   = sys_addr_q;
        blk_addr_d   = blk_addr_q;
        err_blk_d    = err_blk_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        retire       = 1'b0;
        fail         = 1'b0;

        // Pulse outputs are set on the transition so they are high for the whole entry cycle.
        case (state_q)
            S_IDLE: begin
                if (enable && pending) begin
                    state_d = S_RD_SYS;
                    bd_re_d = 1'b1;
                end
            end
            S_RD_SYS: begin
                if (bus.bd_ack) begin
                    sys_addr_d = bus.bd_dat;
                    state_d    = S_RD_BLK;
                    bd_re_d    = 1'b1;
                end
            end
            S_RD_BLK: begin
                if (bus.bd_ack) begin
                    blk_addr_d   = bus.bd_dat;
                    state_d      = S_START;
                    xfer_start_d = 1'b1;
                end
            end
            S_START: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tmo_d = tmo_inc;
                // Error beats done beats timeout; tmo_inc counts WAIT cycles including this one.
                if (bus.xfer_err) begin
                    retire = 1'b1;
                    fail   = 1'b1;
                end else if (bus.xfer_done) begin
                    retire = 1'b1;
                end else if (tmo_inc == '1) begin
                    retire = 1'b1;
                    fail   = 1'b1;
                end
            end
            S_CMP:    state_d = S_SETTLE;
            S_SETTLE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (retire) begin
            state_d  = S_CMP;
            bd_cmp_d = 1'b1;
            cnt_d    = cnt_q + 16'd1;
        end
        if (fail) begin
            err_blk_d = blk_addr_q;
        end
        err_d  = fail | (err_q & ~err_clr);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bd_re_q      <= 1'b0;
            bd_cmp_q     <= 1'b0;
            xfer_start_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            sys_addr_q   <= '0;
            blk_addr_q   <= '0;
            err_blk_q    <= '0;
            cnt_q        <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            bd_re_q      <= bd_re_d;
            bd_cmp_q     <= bd_cmp_d;
            xfer_start_q <= xfer_start_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            sys_addr_q   <= sys_addr_d;
            blk_addr_q   <= blk_addr_d;
            err_blk_q    <= err_blk_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
        end
    end

    assign bus.bd_re         = bd_re_q;
    assign bus.bd_cmp        = bd_cmp_q;
    assign bus.xfer_start    = xfer_start_q;
    assign bus.xfer_sys_addr = sys_addr_q;
    assign bus.xfer_blk_addr = blk_addr_q;
    assign busy              = busy_q;
    assign err               = err_q;
    assign err_blk_addr      = err_blk_q;
    assign xfer_cnt          = cnt_q;

endmodule

// File: tb/tb_sd_bd_fetch.sv
// Bench for sd_bd_fetch: BD store and data engine models plus a scoreboard of queued BDs,
// checked at transfer start and at retire.
module tb_sd_bd_fetch;

    localparam int DATA_W = 32;
    localparam int BD_W   = 3;
    localparam int BD_MAX = 4;
    localparam int TMO_W  = 4;

    typedef struct {
        logic [31:0] sys;
        logic [31:0] blk;
        int          mode;  // 0 = done, 1 = err+done same cycle, 2 = no response
        int          dly;
    } bd_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        busy;
    logic        err;
    logic        err_clr;
    logic [31:0] err_blk_addr;
    logic [15:0] xfer_cnt;

    sd_bd_fetch_if #(.DATA_W(DATA_W), .BD_W(BD_W)) bus ();

    sd_bd_fetch #(
        .DATA_W(DATA_W), .BD_W(BD_W), .BD_MAX(BD_MAX), .TMO_W(TMO_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .bus          (bus),
        .busy         (busy),
        .err          (err),
        .err_clr      (err_clr),
        .err_blk_addr (err_blk_addr),
        .xfer_cnt     (xfer_cnt)
    );

    bd_t store_q[$];
    bd_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc = 0;
    int  re_cnt = 0;
    int  cmp_total = 0;
    int  start_total = 0;
    int  last_cmp_cyc = -100;
    int  start_cyc = 0;
    int  cnt_model = 0;
    logic err_model = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_bd(input logic [31:0] sys, input logic [31:0] blk, input int mode, input int dly);
        bd_t e;
        e.sys = sys; e.blk = blk; e.mode = mode; e.dly = dly;
        store_q.push_back(e);
        exp_q.push_back(e);
    endtask

    task automatic wait_cmp(input int n);
        int budget = 300;
        while (cmp_total < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk_val("wait_cmp", cmp_total, n);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_start(input int n);
        int budget = 300;
        while (start_total < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk_val("wait_start", start_total, n);
    endtask

    // BD store, data engine and retire monitor, all sampled/driven on the falling edge.
    initial begin : models
        int  eng_cnt = 0;
        int  eng_mode = 0;
        int  rd_word = 0;
        bit  ack_due = 0;
        bit  cmp_due = 0;
        bd_t e;
        bus.free_bd   = 3'(BD_MAX);
        bus.bd_ack    = 1'b0;
        bus.bd_dat    = '0;
        bus.xfer_done = 1'b0;
        bus.xfer_err  = 1'b0;
        forever begin
            @(negedge clk);
            bus.bd_ack    = 1'b0;
            bus.xfer_done = 1'b0;
            bus.xfer_err  = 1'b0;
            if (!rst_n) begin
                eng_cnt = 0;
                rd_word = 0;
                ack_due = 0;
                cmp_due = 0;
            end else begin
                if (cmp_due) begin
                    void'(store_q.pop_front());
                    cmp_due = 0;
                end
                if (ack_due) begin
                    ack_due = 0;
                    bus.bd_ack = 1'b1;
                    if (store_q.size() != 0)
                        bus.bd_dat = (rd_word == 0) ? store_q[0].sys : store_q[0].blk;
                    rd_word ^= 1;
                end
                if (bus.bd_re) begin
                    re_cnt++;
                    chk_val("re_pending", store_q.size() != 0, 1);
                    if (rd_word == 0)
                        chk_val("re_gap_ok", (cyc - last_cmp_cyc) >= 3, 1);
                    ack_due = 1;
                end
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0) begin
                        bus.xfer_done = 1'b1;
                        bus.xfer_err  = (eng_mode == 1);
                    end
                end
                if (bus.xfer_start) begin
                    start_total++;
                    start_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        chk_val("start_unexpected", 1, 0);
                    end else begin
                        chk_val("start_sys", bus.xfer_sys_addr, exp_q[0].sys);
                        chk_val("start_blk", bus.xfer_blk_addr, exp_q[0].blk);
                        eng_mode = exp_q[0].mode;
                        eng_cnt  = (eng_mode == 2) ? 0 : exp_q[0].dly;
                    end
                end
                if (bus.bd_cmp) begin
                    cmp_due = 1;
                    if (exp_q.size() == 0) begin
                        chk_val("cmp_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        cnt_model++;
                        err_model = err_model | (e.mode != 0);
                        chk_val("cmp_blk", bus.xfer_blk_addr, e.blk);
                        chk_val("cmp_sys", bus.xfer_sys_addr, e.sys);
                        chk_val("cmp_cnt", xfer_cnt, cnt_model);
                        chk_val("cmp_err", err, err_model);
                        if (e.mode != 0) chk_val("cmp_err_blk", err_blk_addr, e.blk);
                        if (e.mode == 2) chk_val("tmo_latency", cyc - start_cyc, 16);
                    end
                    cmp_total++;
                    last_cmp_cyc = cyc;
                end
            end
            bus.free_bd = 3'(BD_MAX - store_q.size());
        end
    end

    initial begin : main
        rst_n   = 1'b0;
        enable  = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk_val("rst_bd_re", bus.bd_re, 0);
        chk_val("rst_busy", busy, 0);
        chk_val("rst_cnt", xfer_cnt, 0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        push_bd(32'h1000_0000, 32'h0000_0040, 0, 10);
        wait_cmp(1);
        chk_val("single_re", re_cnt, 2);
        chk_val("single_err", err, 0);
        chk_val("single_cnt", xfer_cnt, 1);
        chk_val("single_sys", bus.xfer_sys_addr, 32'h1000_0000);
        chk_val("single_busy", busy, 0);

        push_bd(32'h1100_0000, 32'h0000_0100, 0, 3);
        push_bd(32'h1200_0000, 32'h0000_0200, 0, 5);
        wait_cmp(3);
        repeat (10) @(negedge clk);
        chk_val("b2b_re", re_cnt, 6);
        chk_val("b2b_cnt", xfer_cnt, 3);
        chk_val("b2b_cmp", cmp_total, 3);

        push_bd(32'h2000_0000, 32'h0000_0055, 1, 4);
        wait_cmp(4);
        chk_val("prec_err", err, 1);
        chk_val("prec_err_blk", err_blk_addr, 32'h55);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        err_model = 1'b0;
        chk_val("clr_err", err, 0);
        chk_val("clr_err_blk", err_blk_addr, 32'h55);

        push_bd(32'h3000_0000, 32'h0000_0077, 2, 0);
        wait_cmp(5);
        chk_val("tmo_err", err, 1);
        chk_val("tmo_err_blk", err_blk_addr, 32'h77);

        push_bd(32'h4100_0000, 32'h0000_0410, 0, 12);
        push_bd(32'h4200_0000, 32'h0000_0420, 0, 2);
        wait_start(6);
        enable = 1'b0;
        wait_cmp(6);
        repeat (20) @(negedge clk);
        chk_val("en_hold_re", re_cnt, 12);
        chk_val("en_hold_cmp", cmp_total, 6);
        chk_val("en_hold_busy", busy, 0);
        chk_val("en_hold_free", bus.free_bd, 3);
        enable = 1'b1;
        wait_cmp(7);
        chk_val("en_resume_re", re_cnt, 14);
        chk_val("en_resume_cnt", xfer_cnt, 7);

        push_bd(32'h5000_0000, 32'h0000_0099, 0, 8);
        wait_start(8);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        cnt_model = 0;
        err_model = 1'b0;
        #1;
        chk_val("mid_rst_cmp", bus.bd_cmp, 0);
        chk_val("mid_rst_start", bus.xfer_start, 0);
        chk_val("mid_rst_busy", busy, 0);
        chk_val("mid_rst_err", err, 0);
        chk_val("mid_rst_cnt", xfer_cnt, 0);
        chk_val("mid_rst_sys", bus.xfer_sys_addr, 0);
        chk_val("mid_rst_blk", bus.xfer_blk_addr, 0);
        chk_val("mid_rst_err_blk", err_blk_addr, 0);
        chk_val("mid_rst_retired", cmp_total, 7);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_cmp(8);
        chk_val("post_rst_cnt", xfer_cnt, 1);
        chk_val("post_rst_err", err, 0);
        chk_val("post_rst_re", re_cnt, 18);

        repeat (10) @(negedge clk);
        chk_val("end_exp_empty", exp_q.size(), 0);
        chk_val("end_store_empty", store_q.size(), 0);
        chk_val("end_re", re_cnt, 18);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
